usb_tx_packetizer: RTL and testbench
====================================

# usb_tx_packetizer

Low-speed USB packet sequencer that drives the byte-level handshake of `usb_tx`. On a start request from the SIE it emits a handshake packet (PID only) or a data packet (PID, payload, CRC16) as a byte stream. Payload bytes are fetched from the endpoint buffer through a synchronous read port. It owns `valid` sequencing: SYNC start, per-byte refill and EOP trigger. It returns `busy`/`done` status to the SIE.

## Interface
Parameters:
- `MAX_LEN`, 8: maximum payload bytes (low-speed limit).
- `AW`, 3: buffer address width; must satisfy 2^AW ≥ MAX_LEN.

Ports:
- `clk` input 1: system clock (24 MHz).
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `pid` input 4: PID code, sampled with `start`.
- `len` input 4: payload length, sampled with `start`; values above MAX_LEN saturate to MAX_LEN; ignored for handshake PIDs.
- `rd_addr` output AW: buffer read address.
- `rd_data` input 8: buffer data, valid one cycle after `rd_addr`.
- `tx_data` output 8: byte to `usb_tx`.
- `tx_valid` output 1: to `usb_tx` `valid`.
- `tx_ready` input 1: from `usb_tx` `ready`; one-cycle pulse when `tx_data` is captured.
- `busy` output 1: packet in progress.
- `done` output 1: one-cycle pulse when packet is complete.

## Operation
- PID byte = {~pid, pid}.
- Data PIDs are DATA0 = 4'b0011 and DATA1 = 4'b1011. Every other PID is a handshake: the PID byte only, with no payload and no CRC.
- CRC16:
  - Polynomial 0x8005, reflected (LSB-first) processing, init 0xFFFF.
  - Updated bytewise with each payload byte as it is loaded into `tx_data`.
  - Transmitted as ~crc, low byte first.
  - Zero-length data packet gives CRC bytes 0x00 0x00.
- State machine:
  - IDLE: `start` → PID. Latch `pid`/`len`, drive `tx_data`=PID byte, `tx_valid`=1, `rd_addr`=0, crc=0xFFFF, byte index i=0.
  - PID: on `tx_ready`, go to DATA if data PID and len>0 (load `rd_data` into `tx_data`), CRC_LO if data PID and len=0, DRAIN if handshake.
  - DATA: a byte is in `tx_data`, crc includes it, `rd_addr`=i+1. On `tx_ready`, if i+1<len, load the next byte (already fetched), i++. Otherwise load ~crc[7:0] and go to CRC_LO.
  - CRC_LO: on `tx_ready`, load ~crc[15:8] and go to CRC_HI.
  - CRC_HI: on `tx_ready` → DRAIN.
  - DRAIN: final byte is captured but not yet serialized. `tx_valid` stays 1. On the next `tx_ready` (capture of a don't-care byte), `tx_valid`=0, pulse `done`, go to IDLE.
- `tx_data` changes only in the cycle after a `tx_ready` pulse or the `start` acceptance. It holds otherwise.
- `start` while not IDLE is ignored and has no side effects.

## Timing
- Reset values:
  - state=IDLE, `tx_valid`=0, `tx_data`=0x00, `rd_addr`=0, `busy`=0, `done`=0, crc=0xFFFF.
  - Reset mid-packet forces `tx_valid`=0 at the next edge. `usb_tx` is reset by the same signal.
- `start` at edge n gives `tx_valid`=1, `busy`=1 and a valid `tx_data` from edge n+1.
- Byte reload: `tx_data` updates at the edge after the `tx_ready` cycle, well inside the 128-clock byte slot. `rd_data` for byte i+1 is sampled ≥2 cycles after `rd_addr` changes.
- `busy` is high from the cycle after `start` acceptance through the cycle `done` pulses. It is low in the cycle after `done`.
- `tx_ready` arriving in IDLE is ignored.
- Arithmetic widths:
  - i is AW+1 bits wide, so len=MAX_LEN does not wrap.
  - `rd_addr` = i+1 truncated to AW; it wraps only after the last fetch, which is unused.
- Back-to-back: `start` in the cycle after `done` is accepted.

## Test plan
- ACK (pid 4'b0010), start → one captured byte 0xD2, then one drain `tx_ready`, then `tx_valid` falls and `done` pulses. Bus shows SYNC, D2, EOP.
- DATA0 len=0 → captured bytes C3, 00, 00; `rd_addr` never read; `done` after 4th `tx_ready`.
- DATA1 len=4, buffer 00 01 02 03 → captured bytes 4B, 00, 01, 02, 03, then CRC lo/hi bit-exact against the reference model (0x8005 reflected, init 0xFFFF, inverted); `busy` high throughout.
- DATA0 len=15 → saturates to 8 payload bytes, 11 captured bytes total, `rd_addr` sequence 0..7.
- `start` pulsed mid-packet → ignored; captured-byte stream unchanged.
- `reset` asserted after 2nd `tx_ready` → `tx_valid`=0, `busy`=0 at next edge; the following `start` produces a clean packet from its PID.

Source files
------------

// File: rtl/usb_tx_packetizer.sv
// Low-speed USB TX sequencer: emits PID-only or PID/payload/CRC16 byte streams to usb_tx.
// All outputs registered; each byte reload lands on the edge after a tx_ready pulse.
module usb_tx_packetizer #(
  parameter int MAX_LEN = 8,
  parameter int AW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    pid,
  input  logic [3:0]    len,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_DRAIN
  } state_t;

  localparam logic [3:0]  PID_DATA0 = 4'b0011;
  localparam logic [3:0]  PID_DATA1 = 4'b1011;
  localparam logic [AW:0] ONE       = (AW+1)'(1);
  localparam logic [AW:0] MAX_LEN_W = (AW+1)'(MAX_LEN);

  state_t        state_q;
  logic          is_data_q;
  logic [AW:0]   len_q;
  logic [AW:0]   i_q;
  logic [15:0]   crc_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] rd_addr_q;

  logic [AW:0]   len_d;
  logic [AW:0]   i_d;
  logic [15:0]   crc_d;

  // Reflected form of poly 0x8005 (0xA001), shifting LSB-first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    len_d = ({28'd0, len} > 32'(MAX_LEN)) ? MAX_LEN_W : (AW+1)'(len);
    i_d   = i_q + ONE;
    crc_d = crc16_upd(crc_q, rd_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_data_q  <= 1'b0;
      len_q      <= '0;
      i_q        <= '0;
      crc_q      <= 16'hFFFF;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            state_q    <= S_PID;
            is_data_q  <= (pid == PID_DATA0) || (pid == PID_DATA1);
            len_q      <= len_d;
            i_q        <= '0;
            crc_q      <= 16'hFFFF;
            rd_addr_q  <= '0;
            tx_data_q  <= {~pid, pid};
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_PID: begin
          if (tx_ready) begin
            if (!is_data_q) begin
              state_q <= S_DRAIN;
            end else if (len_q != '0) begin
              tx_data_q <= rd_data;
              crc_q     <= crc_d;
              rd_addr_q <= AW'(1);
              state_q   <= S_DATA;
            end else begin
              tx_data_q <= ~crc_q[7:0];
              state_q   <= S_CRC_LO;
            end
          end
        end
        S_DATA: begin
          // rd_addr runs one ahead of i, so the next byte is already on rd_data.
          if (tx_ready) begin
            if (i_d < len_q) begin
              tx_data_q <= rd_data;
              crc_q     <= crc_d;
              i_q       <= i_d;
              rd_addr_q <= rd_addr_q + AW'(1);
            end else begin
              tx_data_q <= ~crc_q[7:0];
              state_q   <= S_CRC_LO;
            end
          end
        end
        S_CRC_LO: begin
          if (tx_ready) begin
            tx_data_q <= ~crc_q[15:8];
            state_q   <= S_CRC_HI;
          end
        end
        S_CRC_HI: begin
          if (tx_ready) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Bench for usb_tx_packetizer: usb_tx handshake model, synchronous buffer model and
// a byte scoreboard fed at packet issue, drained by a monitor on each tx_ready capture.
module tb_usb_tx_packetizer;
  localparam int MAX_LEN = 8;
  localparam int AW      = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    pid;
  logic [3:0]    len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  usb_tx_packetizer #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .pid(pid), .len(len),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  typedef struct {
    bit         drain;
    logic [7:0] b;
  } exp_t;

  exp_t          exp_q[$];
  logic [7:0]    mem[MAX_LEN];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cap_cnt = 0;
  int            gap = 0;
  bit            drain_pend = 0;
  bit            force_rdy = 0;
  logic [AW-1:0] buf_addr;
  exp_t          mon_e;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Bit-serial non-reflected CRC on bit-reversed input, reflected and inverted at the end.
  function automatic logic [15:0] usb_crc(input int n);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 8; b++) begin
        fb = mem[k][b] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int j = 0; j < 16; j++) r[j] = c[15-j];
    return ~r;
  endfunction

  // Synchronous-read endpoint buffer: address seen in cycle k, data after the next edge.
  initial begin
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      buf_addr = rd_addr;
      @(posedge clk);
      #1;
      rd_data = mem[buf_addr];
    end
  end

  // usb_tx handshake model: one-cycle ready pulse every third cycle while valid.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      if (force_rdy) begin
        tx_ready = 1'b1;
      end else if (tx_valid === 1'b1 && !reset) begin
        gap++;
        if (gap >= 3) begin
          tx_ready = 1'b1;
          gap = 0;
        end
      end else begin
        gap = 0;
      end
    end
  end

  // Monitor: pops one expected entry per capture; a drain entry expects done next cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (drain_pend) begin
        chk("done_pulse", 16'(done), 16'd1);
        chk("valid_fall", 16'(tx_valid), 16'd0);
        drain_pend = 0;
      end else if (done === 1'b1) begin
        fail_now("spurious_done");
      end
      if (tx_ready === 1'b1 && tx_valid === 1'b1 && !reset) begin
        cap_cnt++;
        chk("busy_in_pkt", 16'(busy), 16'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_capture: got byte 0x%h, want no capture", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.drain) drain_pend = 1;
          else chk($sformatf("byte%0d", cap_cnt), 16'(tx_data), 16'(mon_e.b));
        end
      end
    end
  end

  task automatic push_b(input logic [7:0] b);
    exp_t e;
    e.drain = 0;
    e.b     = b;
    exp_q.push_back(e);
  endtask

  task automatic push_drain();
    exp_t e;
    e.drain = 1;
    e.b     = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [3:0] p, input logic [3:0] l);
    int          n;
    logic [15:0] c;
    push_b({~p, p});
    if (p == 4'b0011 || p == 4'b1011) begin
      n = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      for (int k = 0; k < n; k++) push_b(mem[k]);
      c = usb_crc(n);
      push_b(c[7:0]);
      push_b(c[15:8]);
    end
    push_drain();
    @(posedge clk);
    #1;
    chk("busy_before_start", 16'(busy), 16'd0);
    start = 1'b1;
    pid   = p;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("valid_after_start", 16'(tx_valid), 16'd1);
    chk("busy_after_start", 16'(busy), 16'd1);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (done !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) fail_now({name, "_timeout"});
    else chk({name, "_queue_empty"}, 16'(exp_q.size()), 16'd0);
  endtask

  task automatic wait_caps(input int target);
    int t;
    t = 0;
    while (cap_cnt < target && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 2000) fail_now("capture_timeout");
  endtask

  int base;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pid   = 4'h0;
    len   = 4'h0;
    for (int k = 0; k < MAX_LEN; k++) mem[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 16'(tx_valid), 16'd0);
    chk("rst_tx_data", 16'(tx_data), 16'h0000);
    chk("rst_rd_addr", 16'(rd_addr), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    reset = 1'b0;

    // tx_ready while idle must not start anything
    force_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    force_rdy = 1'b0;
    @(negedge clk);
    chk("idle_ready_valid", 16'(tx_valid), 16'd0);
    chk("idle_ready_busy", 16'(busy), 16'd0);

    // ACK with a nonzero len: PID byte D2 only
    send(4'b0010, 4'd5);
    wait_done("ack");
    // NAK back-to-back in the cycle after done
    send(4'b1010, 4'd0);
    wait_done("nak");

    // DATA0 zero length: C3 00 00
    send(4'b0011, 4'd0);
    wait_done("data0_len0");

    // DATA1 len 4 with a stray start mid-packet
    for (int k = 0; k < MAX_LEN; k++) mem[k] = 8'(k);
    base = cap_cnt;
    send(4'b1011, 4'd4);
    wait_caps(base + 2);
    start = 1'b1;
    pid   = 4'b1110;
    len   = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("data1_len4");
    chk("data1_len4_caps", 16'(cap_cnt - base), 16'd8);

    // DATA0 len 15 saturates to 8 payload bytes
    for (int k = 0; k < MAX_LEN; k++) mem[k] = 8'hA0 + 8'(k * 3);
    base = cap_cnt;
    send(4'b0011, 4'd15);
    wait_done("data0_len15");
    chk("data0_len15_caps", 16'(cap_cnt - base), 16'd12);

    // reset after the second capture of a DATA1 packet
    for (int k = 0; k < MAX_LEN; k++) mem[k] = 8'h5C ^ 8'(k);
    base = cap_cnt;
    send(4'b1011, 4'd6);
    wait_caps(base + 2);
    reset = 1'b1;
    exp_q.delete();
    drain_pend = 0;
    @(posedge clk);
    #1;
    chk("midrst_tx_valid", 16'(tx_valid), 16'd0);
    chk("midrst_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    send(4'b0011, 4'd3);
    wait_done("post_reset");

    repeat (4) @(posedge clk);
    chk("final_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
